// File: rtl/stack_push_sequencer.sv
// Stack push sequencer: turns CALL/INT requests into timed 16-bit stack writes
// and owns the stack pointer shared with the pop side.
module stack_push_sequencer #(
    parameter int unsigned             ADDR_W  = 11,
    parameter logic [ADDR_W-1:0]       SP_INIT = 11'h7FF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              call_req,
    input  logic              int_req,
    input  logic [31:0]       pc_in,
    input  logic [2:0]        flags_in,
    input  logic              pop_step,
    output logic              busy,
    output logic [1:0]        push_segment,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W-1:0] pop_addr,
    output logic [ADDR_W-1:0] sp_out,
    output logic              done,
    output logic              stack_err
);

    // state  | meaning
    // IDLE   | waiting for CALL/INT; pop_step increments SP
    // PUSH_H | writing pc_h at SP
    // PUSH_L | writing pc_l at SP; last write for CALL
    // PUSH_F | writing flags at SP; last write for INT
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PUSH_H = 2'd1,
        PUSH_L = 2'd2,
        PUSH_F = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [31:0]       pc_q, pc_d;
    logic [2:0]        flags_q, flags_d;
    logic              is_int_q, is_int_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sp_q     <= SP_INIT;
            pc_q     <= 32'h0;
            flags_q  <= 3'b000;
            is_int_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            pc_q     <= pc_d;
            flags_q  <= flags_d;
            is_int_q <= is_int_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        pc_d         = pc_q;
        flags_d      = flags_q;
        is_int_d     = is_int_q;
        err_d        = err_q;
        busy         = 1'b0;
        mem_write    = 1'b0;
        push_segment = 2'b00;
        mem_wdata    = 16'h0000;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop_step) begin
                    if (sp_q == SP_INIT) err_d = 1'b1;
                    sp_d = sp_q + ONE;
                end
                if (int_req) begin
                    pc_d     = pc_in;
                    flags_d  = flags_in;
                    is_int_d = 1'b1;
                    state_d  = PUSH_H;
                end else if (call_req) begin
                    pc_d     = pc_in;
                    flags_d  = flags_in;
                    is_int_d = 1'b0;
                    state_d  = PUSH_H;
                end
            end
            PUSH_H: begin
                busy         = 1'b1;
                mem_write    = 1'b1;
                push_segment = 2'b11;
                mem_wdata    = pc_q[31:16];
                state_d      = PUSH_L;
            end
            PUSH_L: begin
                busy         = 1'b1;
                mem_write    = 1'b1;
                push_segment = 2'b10;
                mem_wdata    = pc_q[15:0];
                if (is_int_q) begin
                    state_d = PUSH_F;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            PUSH_F: begin
                busy         = 1'b1;
                mem_write    = 1'b1;
                push_segment = 2'b01;
                mem_wdata    = {13'b0, flags_q};
                done         = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every busy cycle is a post-decrement push; a pop here collides with it.
        if (state_q != IDLE) begin
            sp_d = sp_q - ONE;
            if (sp_q == '0) err_d = 1'b1;
            if (pop_step)   err_d = 1'b1;
        end
    end

    assign mem_addr  = sp_q;
    assign pop_addr  = sp_q + ONE;
    assign sp_out    = sp_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_stack_push_sequencer.sv
// Self-checking bench for stack_push_sequencer: directed vector table,
// a stack-wrap sequence, and randomized traffic against a queue-based model.
module tb_stack_push_sequencer;

    logic        clk = 1'b0;
    logic        reset, call_req, int_req, pop_step;
    logic [31:0] pc_in;
    logic [2:0]  flags_in;
    logic        busy, mem_write, done, stack_err;
    logic [1:0]  push_segment;
    logic [10:0] mem_addr, pop_addr, sp_out;
    logic [15:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    stack_push_sequencer dut (
        .clk(clk), .reset(reset), .call_req(call_req), .int_req(int_req),
        .pc_in(pc_in), .flags_in(flags_in), .pop_step(pop_step),
        .busy(busy), .push_segment(push_segment), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pop_addr(pop_addr),
        .sp_out(sp_out), .done(done), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Directed vectors: inputs applied for one cycle, outputs expected after that edge.
    typedef struct {
        bit          rst, call, intr;
        logic [31:0] pc;
        logic [2:0]  fl;
        bit          pop;
        bit          busy;
        logic [1:0]  seg;
        bit          wr;
        logic [10:0] addr;
        logic [15:0] data;
        bit          done;
        logic [10:0] sp, paddr;
        bit          err;
    } vec_t;

    vec_t vecs[24];

    // Reference model: a queue of pending writes plus SP and sticky error.
    typedef struct { logic [15:0] data; logic [1:0] seg; bit last; } wr_t;
    wr_t         mq[$];
    int unsigned m_sp;
    bit          m_err;

    task automatic model_reset();
        mq.delete();
        m_sp  = 11'h7FF;
        m_err = 1'b0;
    endtask

    task automatic model_compare(input string tag);
        bit          e_busy;
        logic [15:0] e_data;
        logic [1:0]  e_seg;
        bit          e_done;
        e_busy = (mq.size() != 0);
        e_data = e_busy ? mq[0].data : 16'h0;
        e_seg  = e_busy ? mq[0].seg  : 2'b00;
        e_done = e_busy ? mq[0].last : 1'b0;
        chk({tag, " busy"},      busy,         e_busy);
        chk({tag, " mem_write"}, mem_write,    e_busy);
        chk({tag, " seg"},       push_segment, e_seg);
        chk({tag, " wdata"},     mem_wdata,    e_data);
        chk({tag, " done"},      done,         e_done);
        chk({tag, " addr"},      mem_addr,     m_sp);
        chk({tag, " sp"},        sp_out,       m_sp);
        chk({tag, " pop_addr"},  pop_addr,     (m_sp + 1) % 2048);
        chk({tag, " err"},       stack_err,    m_err);
    endtask

    task automatic model_update(input bit rst, c, i, input logic [31:0] pc,
                                input logic [2:0] fl, input bit pop);
        if (rst) begin
            model_reset();
        end else if (mq.size() != 0) begin
            if (m_sp == 0) m_err = 1'b1;
            if (pop) m_err = 1'b1;
            m_sp = (m_sp + 2047) % 2048;
            void'(mq.pop_front());
        end else begin
            if (pop) begin
                if (m_sp == 11'h7FF) m_err = 1'b1;
                m_sp = (m_sp + 1) % 2048;
            end
            if (i) begin
                mq.push_back('{pc[31:16], 2'b11, 1'b0});
                mq.push_back('{pc[15:0],  2'b10, 1'b0});
                mq.push_back('{{13'b0, fl}, 2'b01, 1'b1});
            end else if (c) begin
                mq.push_back('{pc[31:16], 2'b11, 1'b0});
                mq.push_back('{pc[15:0],  2'b10, 1'b1});
            end
        end
    endtask

    // Called at a negedge: compare, drive, advance model, move to next negedge.
    task automatic step(input string tag, input bit rst, c, i, input logic [31:0] pc,
                        input logic [2:0] fl, input bit pop);
        model_compare(tag);
        reset = rst; call_req = c; int_req = i; pc_in = pc; flags_in = fl; pop_step = pop;
        model_update(rst, c, i, pc, fl, pop);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //        rst call int pc            fl    pop busy seg   wr addr     data      done sp       paddr    err
        vecs[0]  = '{1, 0, 0, 32'h0,         3'd0, 0,  0, 2'b00, 0, 11'h7FF, 16'h0000, 0, 11'h7FF, 11'h000, 0};
        vecs[1]  = '{0, 0, 0, 32'h0,         3'd0, 0,  0, 2'b00, 0, 11'h7FF, 16'h0000, 0, 11'h7FF, 11'h000, 0};
        vecs[2]  = '{0, 0, 0, 32'h0,         3'd0, 0,  0, 2'b00, 0, 11'h7FF, 16'h0000, 0, 11'h7FF, 11'h000, 0};
        vecs[3]  = '{0, 0, 0, 32'h0,         3'd0, 0,  0, 2'b00, 0, 11'h7FF, 16'h0000, 0, 11'h7FF, 11'h000, 0};
        vecs[4]  = '{0, 1, 0, 32'h0001_2345, 3'd0, 0,  1, 2'b11, 1, 11'h7FF, 16'h0001, 0, 11'h7FF, 11'h000, 0};
        vecs[5]  = '{0, 0, 0, 32'h0,         3'd0, 0,  1, 2'b10, 1, 11'h7FE, 16'h2345, 1, 11'h7FE, 11'h7FF, 0};
        vecs[6]  = '{0, 0, 0, 32'h0,         3'd0, 0,  0, 2'b00, 0, 11'h7FD, 16'h0000, 0, 11'h7FD, 11'h7FE, 0};
        vecs[7]  = '{1, 0, 0, 32'h0,         3'd0, 0,  0, 2'b00, 0, 11'h7FF, 16'h0000, 0, 11'h7FF, 11'h000, 0};
        vecs[8]  = '{0, 1, 1, 32'h00AB_CDEF, 3'd5, 0,  1, 2'b11, 1, 11'h7FF, 16'h00AB, 0, 11'h7FF, 11'h000, 0};
        vecs[9]  = '{0, 0, 0, 32'h0,         3'd0, 0,  1, 2'b10, 1, 11'h7FE, 16'hCDEF, 0, 11'h7FE, 11'h7FF, 0};
        vecs[10] = '{0, 0, 0, 32'h0,         3'd0, 0,  1, 2'b01, 1, 11'h7FD, 16'h0005, 1, 11'h7FD, 11'h7FE, 0};
        vecs[11] = '{0, 0, 0, 32'h0,         3'd0, 0,  0, 2'b00, 0, 11'h7FC, 16'h0000, 0, 11'h7FC, 11'h7FD, 0};
        vecs[12] = '{0, 0, 0, 32'h0,         3'd0, 1,  0, 2'b00, 0, 11'h7FD, 16'h0000, 0, 11'h7FD, 11'h7FE, 0};
        vecs[13] = '{0, 0, 0, 32'h0,         3'd0, 1,  0, 2'b00, 0, 11'h7FE, 16'h0000, 0, 11'h7FE, 11'h7FF, 0};
        vecs[14] = '{0, 0, 0, 32'h0,         3'd0, 1,  0, 2'b00, 0, 11'h7FF, 16'h0000, 0, 11'h7FF, 11'h000, 0};
        vecs[15] = '{0, 1, 0, 32'h1111_2222, 3'd0, 0,  1, 2'b11, 1, 11'h7FF, 16'h1111, 0, 11'h7FF, 11'h000, 0};
        vecs[16] = '{0, 0, 0, 32'h0,         3'd0, 1,  1, 2'b10, 1, 11'h7FE, 16'h2222, 1, 11'h7FE, 11'h7FF, 1};
        vecs[17] = '{0, 1, 0, 32'h3333_4444, 3'd0, 0,  0, 2'b00, 0, 11'h7FD, 16'h0000, 0, 11'h7FD, 11'h7FE, 1};
        vecs[18] = '{0, 0, 0, 32'h0,         3'd0, 0,  0, 2'b00, 0, 11'h7FD, 16'h0000, 0, 11'h7FD, 11'h7FE, 1};
        vecs[19] = '{1, 0, 0, 32'h0,         3'd0, 0,  0, 2'b00, 0, 11'h7FF, 16'h0000, 0, 11'h7FF, 11'h000, 0};
        vecs[20] = '{0, 0, 1, 32'h1234_5678, 3'd3, 0,  1, 2'b11, 1, 11'h7FF, 16'h1234, 0, 11'h7FF, 11'h000, 0};
        vecs[21] = '{0, 0, 0, 32'h0,         3'd0, 0,  1, 2'b10, 1, 11'h7FE, 16'h5678, 0, 11'h7FE, 11'h7FF, 0};
        vecs[22] = '{1, 0, 0, 32'h0,         3'd0, 0,  0, 2'b00, 0, 11'h7FF, 16'h0000, 0, 11'h7FF, 11'h000, 0};
        vecs[23] = '{0, 0, 0, 32'h0,         3'd0, 1,  0, 2'b00, 0, 11'h000, 16'h0000, 0, 11'h000, 11'h001, 1};

        reset = 1'b1; call_req = 1'b0; int_req = 1'b0; pop_step = 1'b0;
        pc_in = 32'h0; flags_in = 3'd0;
        @(negedge clk);

        for (int v = 0; v < 24; v++) begin
            string t;
            t = $sformatf("vec%0d", v);
            reset = vecs[v].rst; call_req = vecs[v].call; int_req = vecs[v].intr;
            pc_in = vecs[v].pc; flags_in = vecs[v].fl; pop_step = vecs[v].pop;
            @(posedge clk);
            @(negedge clk);
            chk({t, " busy"},      busy,         vecs[v].busy);
            chk({t, " seg"},       push_segment, vecs[v].seg);
            chk({t, " mem_write"}, mem_write,    vecs[v].wr);
            chk({t, " addr"},      mem_addr,     vecs[v].addr);
            chk({t, " wdata"},     mem_wdata,    vecs[v].data);
            chk({t, " done"},      done,         vecs[v].done);
            chk({t, " sp"},        sp_out,       vecs[v].sp);
            chk({t, " pop_addr"},  pop_addr,     vecs[v].paddr);
            chk({t, " err"},       stack_err,    vecs[v].err);
        end

        // Push through SP=0: 1023 CALLs bring SP to 1, the next one writes at 1 and 0.
        reset = 1'b1; call_req = 1'b0; int_req = 1'b0; pop_step = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        for (int k = 0; k < 1023; k++) begin
            step("wrap", 0, 1, 0, 32'(k), 3'd0, 0);
            step("wrap", 0, 0, 0, 32'h0,  3'd0, 0);
            step("wrap", 0, 0, 0, 32'h0,  3'd0, 0);
        end
        chk("wrap sp_before", sp_out, 11'h001);
        chk("wrap err_before", stack_err, 1'b0);
        step("wrap", 0, 1, 0, 32'hDEAD_BEEF, 3'd0, 0);
        step("wrap", 0, 0, 0, 32'h0, 3'd0, 0);
        step("wrap", 0, 0, 0, 32'h0, 3'd0, 0);
        chk("wrap sp_after", sp_out, 11'h7FF);
        chk("wrap err_after", stack_err, 1'b1);

        // Randomized traffic, including held requests for back-to-back sequences.
        step("rnd", 1, 0, 0, 32'h0, 3'd0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit r, c, i, p;
            r = ($urandom_range(0, 79) == 0);
            c = ($urandom_range(0, 2) == 0);
            i = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 2) == 0);
            step("rnd", r, c, i, $urandom, 3'($urandom), p);
        end
        model_compare("rnd_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_push_sequencer.md
Name: stack_push_sequencer

Overview:
- Write-side counterpart of the MEM/WB pop capture.
- Turns a CALL or INT request into a timed series of 16-bit data-memory writes.
- Push order: pc_h, then pc_l, then flags (INT only). The pop side therefore sees flags first, then pc_l, then pc_h.
- Owns the stack pointer. Takes single-step increments from the pop side (RET/RTI). Sits beside the memory stage and stalls the front end while a sequence runs.

Parameters:
- ADDR_W, 11, width of the stack pointer and of the memory address.
- SP_INIT, 11'h7FF, stack pointer value after reset (empty stack).

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  reset, synchronous, active-high
- call_req  input  1  start a 2-segment push (pc_h, pc_l); sampled in IDLE only
- int_req  input  1  start a 3-segment push (pc_h, pc_l, flags); sampled in IDLE only
- pc_in  input  32  return PC; [31:16]=pc_h, [15:0]=pc_l; latched on accept
- flags_in  input  3  CCR flags; latched on accept
- pop_step  input  1  pop side consumed one word; increment SP
- busy  output  1  sequence in progress; front-end stall
- push_segment  output  2  11=pc_h, 10=pc_l, 01=flags, 00=none
- mem_write  output  1  data-memory write strobe
- mem_addr  output  ADDR_W  write address (= current SP)
- mem_wdata  output  16  write data
- pop_addr  output  ADDR_W  SP+1 modulo 2^ADDR_W; address the pop side reads
- sp_out  output  ADDR_W  current stack pointer
- done  output  1  high during the final write cycle of a sequence
- stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- States: IDLE, PUSH_H, PUSH_L, PUSH_F. All outputs are Moore, decoded from state and registers.
- Reset (synchronous, overrides everything, including mid-sequence):
  - State goes to IDLE and SP to SP_INIT.
  - The latched PC, flags and kind registers go to 0; stack_err goes to 0.
  - A partial sequence is abandoned; already-written words are not undone.
- Outputs in IDLE: busy=0, mem_write=0, push_segment=00, done=0, mem_wdata=0, mem_addr=SP.
- Accept in IDLE:
  - If int_req=1, latch pc_in, flags_in and kind=INT, then go to PUSH_H.
  - Else if call_req=1, latch with kind=CALL, then go to PUSH_H.
  - Simultaneous int_req and call_req: INT wins; the call is dropped.
- Latency: the first write occurs the cycle after the accept edge.
- Requests while busy=1 are ignored. Requesters hold or re-issue after busy falls.
- PUSH_H: mem_write=1, mem_addr=SP, mem_wdata=pc_h, push_segment=11; SP<=SP-1; next state PUSH_L.
- PUSH_L: mem_write=1, mem_addr=SP, mem_wdata=pc_l, push_segment=10; SP<=SP-1.
  - kind=CALL: done=1, next state IDLE.
  - kind=INT: next state PUSH_F.
- PUSH_F: mem_write=1, mem_addr=SP, mem_wdata={13'b0,flags}, push_segment=01, done=1; SP<=SP-1; next state IDLE.
- busy=1 in PUSH_H, PUSH_L and PUSH_F.
- CALL takes 2 write cycles; INT takes 3. Back-to-back: a new request can be accepted the cycle after done.
- Pop (post-decrement push, pre-increment pop):
  - pop_step=1 in IDLE: SP<=SP+1.
  - pop_step while busy=1: ignored and sets stack_err.
- Wrap-around: SP arithmetic is modulo 2^ADDR_W.
  - A push executed with SP=0 sets stack_err and SP wraps to all-ones.
  - pop_step with SP=SP_INIT sets stack_err and SP wraps.
- stack_err is sticky until reset.

Test Plan:
- Reset, then idle 3 cycles -> sp_out=0x7FF, pop_addr=0x000, busy=0, mem_write=0, push_segment=00, stack_err=0.
- call_req pulse with pc_in=0x0001_2345 ->
  - cycle1: write addr 0x7FF data 0x0001 seg 11.
  - cycle2: write addr 0x7FE data 0x2345 seg 10, done=1.
  - After: sp_out=0x7FD, busy low on cycle3.
- int_req and call_req together, pc_in=0x00AB_CDEF, flags_in=3'b101 ->
  - Writes (0x7FF,0x00AB,11), (0x7FE,0xCDEF,10), (0x7FD,0x0005,01).
  - done on the third write; sp_out=0x7FC.
- After the INT above, three pop_step pulses in IDLE -> pop_addr sequence 0x7FD, 0x7FE, 0x7FF before each step; final sp_out=0x7FF; stack_err=0.
- call_req re-asserted during PUSH_L and pop_step during PUSH_H -> the request is ignored (only 2 writes), SP unchanged by the pop, stack_err=1.
- Reset asserted in PUSH_L of an INT -> the next cycle is IDLE with mem_write=0 and sp_out=0x7FF. A 4th pop_step from SP=0x7FF -> stack_err=1 and sp_out=0x000.
